// File: rtl/int2flt_pkg.sv
// int2flt_pkg
//   Shared types and constants for the 8.8 fixed-point -> half-float sequencer.
//   state_t    : sequencer FSM states
//   FLT_BIAS   : half-float exponent bias
//   FIX_FRAC   : fractional bits of the 8.8 operand
//   EXP_TOP    : exponent when the operand MSB is already at bit 15
//   ZERO_FLT   : encoding written for a zero operand
//   exp_field(): biased exponent for a given normalization shift count
package int2flt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        NORM,
        PACK,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam int          FLT_BIAS = 15;
    localparam int          FIX_FRAC = 8;
    localparam int          EXP_TOP  = FLT_BIAS + FIX_FRAC - 1;
    localparam logic [15:0] ZERO_FLT = 16'h0000;

    // Each left shift during normalization lowers the exponent by one.
    // cnt never exceeds 15, so the result stays in 7..22.
    function automatic logic [4:0] exp_field(input logic [3:0] cnt);
        return 5'(EXP_TOP) - {1'b0, cnt};
    endfunction

endpackage

// File: rtl/int2flt_pack.sv
// int2flt_pack
//   Combinational packer: assembles the half-float word from the
//   normalized magnitude.
//   sign : operand sign bit
//   zero : operand was zero (forces ZERO_FLT)
//   cnt  : number of normalization shifts applied
//   mag  : normalized magnitude, mag[15] is the implicit leading one
//   res  : {sign, exp[4:0], mant[9:0]}, mantissa truncated
module int2flt_pack
    import int2flt_pkg::*;
(
    input  logic        sign,
    input  logic        zero,
    input  logic [3:0]  cnt,
    input  logic [15:0] mag,
    output logic [15:0] res
);

    // The hidden bit and the bits below the 10-bit mantissa are dropped
    // (truncation, no rounding).
    logic unused_mag;
    assign unused_mag = ^{mag[15], mag[4:0]};

    assign res = zero ? ZERO_FLT : {sign, exp_field(cnt), mag[14:5]};

endmodule

// File: rtl/int2flt_sequencer.sv
// int2flt_sequencer
//   Start/done accelerator that reads a 16-bit 8.8 fixed-point operand from
//   data_mem, converts it to an IEEE half layout float (bias 15, truncated
//   mantissa) by shifting one bit per clock, and writes the result back.
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   start       : conversion request, honoured only in IDLE or DONE
//   done        : high in DONE until the next accepted start
//   mem_addr    : data_mem address, decoded from the state
//   mem_rd_data : data_mem combinational read data for mem_addr
//   mem_wr_en   : data_mem write enable, high only in WR_LO / WR_HI
//   mem_wr_data : data_mem write data
module int2flt_sequencer
    import int2flt_pkg::*;
#(
    parameter int AW       = 8,
    parameter int IN_ADDR  = 0,
    parameter int OUT_ADDR = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    state_t      state_q,   state_d;
    logic [7:0]  lo_q,      lo_d;
    logic        sign_q,    sign_d;
    logic        zero_q,    zero_d;
    logic [15:0] mag_q,     mag_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [15:0] res_q,     res_d;
    logic        done_q,    done_d;
    logic        wr_en_q,   wr_en_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [15:0] x;
    logic [15:0] pack_res;

    // Full operand during RD_HI: high byte straight from memory, low byte latched.
    assign x = {mem_rd_data, lo_q};

    int2flt_pack u_pack (
        .sign (sign_q),
        .zero (zero_q),
        .cnt  (cnt_q),
        .mag  (mag_q),
        .res  (pack_res)
    );

    always_comb begin
        // NOTE: every _d gets a default first, so no latches are inferred.
        state_d   = state_q;
        lo_d      = lo_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = RD_LO;
            end
            RD_LO: begin
                lo_d    = mem_rd_data;
                state_d = RD_HI;
            end
            RD_HI: begin
                sign_d  = x[15];
                // Two's complement negate; 0x8000 maps onto itself, which is
                // already the correct magnitude when read as unsigned.
                mag_d   = x[15] ? (~x + 16'd1) : x;
                cnt_d   = 4'd0;
                zero_d  = (x == 16'h0000);
                state_d = (x == 16'h0000) ? PACK : NORM;
            end
            NORM: begin
                if (mag_q[15]) begin
                    state_d = PACK;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PACK: begin
                // Write strobe and low byte are registered one cycle ahead so
                // they are valid for the whole WR_LO cycle.
                res_d     = pack_res;
                wr_en_d   = 1'b1;
                wr_data_d = pack_res[7:0];
                state_d   = WR_LO;
            end
            WR_LO: begin
                wr_en_d   = 1'b1;
                wr_data_d = res_q[15:8];
                state_d   = WR_HI;
            end
            WR_HI: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = RD_LO;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lo_q      <= 8'h00;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            mag_q     <= 16'h0000;
            cnt_q     <= 4'd0;
            res_q     <= 16'h0000;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            lo_q      <= lo_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        mem_addr = AW'(IN_ADDR);
        unique case (state_q)
            RD_HI:   mem_addr = AW'(IN_ADDR + 1);
            WR_LO:   mem_addr = AW'(OUT_ADDR);
            WR_HI:   mem_addr = AW'(OUT_ADDR + 1);
            default: mem_addr = AW'(IN_ADDR);
        endcase
    end

    assign done        = done_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_int2flt_sequencer.sv
// tb_int2flt_sequencer
//   Directed and random checks of the fixed-point -> half-float sequencer
//   against a behavioural data_mem and an independent conversion model.
module tb_int2flt_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    int checks = 0;
    int errors = 0;

    // Operand bytes live in op; everything else lives in mem, which only
    // the write port below modifies.
    logic [15:0] op = 16'h0000;
    logic [7:0]  mem [256];
    int          wr_total = 0;
    int          cyc = 0;
    logic [7:0]  prev_addr = 8'h00;
    logic [7:0]  last_addr = 8'h00;
    int          e0 = 0;
    int          base = 0;

    int2flt_sequencer #(.AW(8), .IN_ADDR(0), .OUT_ADDR(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = (mem_addr == 8'd0) ? op[7:0] :
                         (mem_addr == 8'd1) ? op[15:8] : mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_total      <= wr_total + 1;
            prev_addr     <= last_addr;
            last_addr     <= mem_addr;
        end
    end

    function automatic logic [15:0] result_word();
        return {mem[3], mem[2]};
    endfunction

    // Reference conversion: locate the MSB, then align it to mantissa bit 10.
    function automatic logic [15:0] model(input logic [15:0] xin, output int k);
        logic [15:0] m;
        logic [15:0] mant;
        int          p;
        m = xin[15] ? (16'h0000 - xin) : xin;
        if (m == 16'h0000) begin
            k = -1;
            return 16'h0000;
        end
        p = 15;
        while (m[p] == 1'b0) p--;
        k = 15 - p;
        if (p >= 10) mant = m >> (p - 10);
        else         mant = m << (10 - p);
        return {xin[15], 5'(7 + p), mant[9:0]};
    endfunction

    // Drives start for one edge (E0) and records E0 and the write count.
    task automatic start_op(input logic [15:0] xin);
        op = xin;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        base  = wr_total;
    endtask

    // Returns edges from E0 to done, or -1 if done never rose.
    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = (done === 1'b1) ? (cyc - e0) : -1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (mem_wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
        checks++; if (mem_wr_data !== 8'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 00", mem_wr_data); end
        checks++; if (mem_addr !== 8'h0)    begin errors++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || wr_total != 0) begin errors++; $display("FAIL idle_hold: done=%b writes=%0d want 0/0", done, wr_total); end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] r;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [6];
        int   lat;
        vecs[0] = '{x: 16'h0030, r: 16'h3200, lat: 16};
        vecs[1] = '{x: 16'h0001, r: 16'h1C00, lat: 21};
        vecs[2] = '{x: 16'hFFFF, r: 16'h9C00, lat: 21};
        vecs[3] = '{x: 16'h7FFF, r: 16'h57FF, lat: 7};
        vecs[4] = '{x: 16'h8000, r: 16'hD800, lat: 6};
        vecs[5] = '{x: 16'h0000, r: 16'h0000, lat: 5};
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].x);
            wait_done(lat);
            checks++; if (lat != vecs[i].lat) begin errors++; $display("FAIL dir_latency x=%h: got %0d want %0d", vecs[i].x, lat, vecs[i].lat); end
            checks++; if (result_word() !== vecs[i].r) begin errors++; $display("FAIL dir_result x=%h: got %h want %h", vecs[i].x, result_word(), vecs[i].r); end
            checks++; if (wr_total - base != 2) begin errors++; $display("FAIL dir_writes x=%h: got %0d want 2", vecs[i].x, wr_total - base); end
            checks++; if (prev_addr !== 8'd2 || last_addr !== 8'd3) begin errors++; $display("FAIL dir_wr_addr x=%h: got %0d,%0d want 2,3", vecs[i].x, prev_addr, last_addr); end
        end
    endtask

    task automatic test_start_during_norm();
        int lat;
        start_op(16'h0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        checks++; if (lat != 21) begin errors++; $display("FAIL norm_start_latency: got %0d want 21", lat); end
        checks++; if (result_word() !== 16'h1C00) begin errors++; $display("FAIL norm_start_result: got %h want 1c00", result_word()); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL norm_start_hold: done=%b want 1", done); end
        checks++; if (wr_total - base != 2) begin errors++; $display("FAIL norm_start_writes: got %0d want 2", wr_total - base); end
    endtask

    task automatic test_start_in_done();
        int lat;
        start_op(16'h0030);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_drop: got %b want 0", done); end
        wait_done(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL restart_latency: got %0d want 16", lat); end
        checks++; if (result_word() !== 16'h3200) begin errors++; $display("FAIL restart_result: got %h want 3200", result_word()); end
    endtask

    task automatic test_operand_change();
        int lat;
        start_op(16'h0300);
        repeat (3) @(posedge clk);
        op = 16'h1234;
        wait_done(lat);
        checks++; if (result_word() !== 16'h4200) begin errors++; $display("FAIL operand_change: got %h want 4200", result_word()); end
        checks++; if (lat != 12) begin errors++; $display("FAIL operand_change_latency: got %0d want 12", lat); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int hold;
        start_op(16'h0001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (done !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL midreset_outputs: done=%b wr_en=%b want 0/0", done, mem_wr_en); end
        checks++; if (mem_addr !== 8'd0 || mem_wr_data !== 8'h00) begin errors++; $display("FAIL midreset_bus: addr=%h data=%h want 00/00", mem_addr, mem_wr_data); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold = wr_total;
        repeat (25) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || wr_total != hold || wr_total != base) begin errors++; $display("FAIL midreset_idle: done=%b writes=%0d want 0/0", done, wr_total - base); end
        start_op(16'h7FFF);
        wait_done(lat);
        checks++; if (result_word() !== 16'h57FF || lat != 7) begin errors++; $display("FAIL midreset_next: got %h lat %0d want 57ff lat 7", result_word(), lat); end
    endtask

    task automatic test_random();
        logic [15:0] xin;
        logic [15:0] want;
        int          k;
        int          lat;
        int          want_lat;
        for (int i = 0; i < 100; i++) begin
            xin      = 16'($urandom);
            want     = model(xin, k);
            want_lat = (k < 0) ? 5 : 6 + k;
            start_op(xin);
            wait_done(lat);
            checks++; if (result_word() !== want || lat != want_lat) begin errors++; $display("FAIL random x=%h: got %h lat %0d want %h lat %0d", xin, result_word(), lat, want, want_lat); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
        test_reset();
        test_directed();
        test_start_during_norm();
        test_start_in_done();
        test_operand_change();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
